// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_if.sv
// Display-side bundle: what a host drives into the scanner and what comes back out.
interface seg7_scan_if #(
  parameter int unsigned N_DIGITS = 8
);
  logic                    scan_clk;
  logic [4*N_DIGITS-1:0]   data;
  logic [N_DIGITS-1:0]     dot;
  logic                    blank_lz;
  logic [N_DIGITS-1:0]     O_AN;
  logic [6:0]              O_SEG;
  logic                    O_DP;
  logic                    frame_done;

  modport master (
    output scan_clk, data, dot, blank_lz,
    input  O_AN, O_SEG, O_DP, frame_done
  );

  modport slave (
    input  scan_clk, data, dot, blank_lz,
    output O_AN, O_SEG, O_DP, frame_done
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scanner: one digit per scan_clk rising edge,
// all anodes dark for BLANK_CYCLES clocks after each digit change.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                  I_CLK,
  input  logic                  rst,
  input  logic                  scan_clk,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dot,
  input  logic                  blank_lz,
  output logic [N_DIGITS-1:0]   O_AN,
  output logic [6:0]            O_SEG,
  output logic                  O_DP,
  output logic                  frame_done
);

  localparam int unsigned        IDX_W    = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0]         CNT_LOAD = 8'(BLANK_CYCLES);

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [4*N_DIGITS-1:0]   r_snapshot;
  logic [N_DIGITS-1:0]     r_dots;
  logic                    r_prev_scan;
  logic [7:0]              r_cnt;
  logic [N_DIGITS-1:0]     r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_wrap;
  logic [IDX_W-1:0]        w_next_idx;
  logic [3:0]              w_nib;
  logic                    w_upper_zero;
  logic                    w_lz_blank;
  logic [6:0]              w_dec_seg;
  logic [6:0]              w_show_seg;
  logic [N_DIGITS-1:0]     w_show_an;
  logic                    w_show_dp;

  assign w_tick     = scan_clk & ~r_prev_scan;
  assign w_wrap     = (r_idx == IDX_LAST);
  assign w_next_idx = w_wrap ? '0 : r_idx + 1'b1;

  // Current nibble, and whether it and every more-significant nibble are zero.
  always_comb begin
    w_nib        = '0;
    w_upper_zero = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IDX_W'(i))
        w_nib = r_snapshot[i*4 +: 4];
      if ((IDX_W'(i) >= r_idx) && (r_snapshot[i*4 +: 4] != 4'h0))
        w_upper_zero = 1'b0;
    end
  end

  seg7_decode u_decode (
    .i_nib (w_nib),
    .o_seg (w_dec_seg)
  );

  assign w_lz_blank = blank_lz && (r_idx != '0) && w_upper_zero;
  assign w_show_seg = w_lz_blank ? SEG_BLANK : w_dec_seg;
  assign w_show_an  = ~(N_DIGITS'(1) << r_idx);
  assign w_show_dp  = ~r_dots[r_idx];

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_snapshot   <= '0;
      r_dots       <= '0;
      r_prev_scan  <= 1'b0;
      r_cnt        <= '0;
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_prev_scan  <= scan_clk;
      r_frame_done <= 1'b0;
      if (w_tick) begin
        // Any tick restarts blanking for the next digit, whatever the state.
        r_cnt   <= CNT_LOAD;
        r_state <= BLANK;
        r_an    <= '1;
        r_seg   <= SEG_BLANK;
        r_dp    <= 1'b1;
        if (r_state == IDLE) begin
          r_idx      <= '0;
          r_snapshot <= data;
          r_dots     <= dot;
        end else begin
          r_idx <= w_next_idx;
          if (w_wrap) begin
            r_snapshot   <= data;
            r_dots       <= dot;
            r_frame_done <= 1'b1;
          end
        end
      end else begin
        unique case (r_state)
          IDLE: ;
          BLANK: begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == 8'd1) begin
              r_state <= SHOW;
              r_an    <= w_show_an;
              r_seg   <= w_show_seg;
              r_dp    <= w_show_dp;
            end
          end
          SHOW: ;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign O_AN       = r_an;
  assign O_SEG      = r_seg;
  assign O_DP       = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with 8 digits and a 4-cycle blank.
module tb_seg7_scan;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_if #(.N_DIGITS(8)) bus ();

  seg7_scan #(
    .N_DIGITS     (8),
    .BLANK_CYCLES (4)
  ) dut (
    .I_CLK      (clk),
    .rst        (rst),
    .scan_clk   (bus.scan_clk),
    .data       (bus.data),
    .dot        (bus.dot),
    .blank_lz   (bus.blank_lz),
    .O_AN       (bus.O_AN),
    .O_SEG      (bus.O_SEG),
    .O_DP       (bus.O_DP),
    .frame_done (bus.frame_done)
  );

  // One-clock-wide scan_clk high; the tick edge lies inside the task.
  task automatic tick();
    @(negedge clk) bus.scan_clk = 1'b1;
    @(negedge clk) bus.scan_clk = 1'b0;
  endtask

  // Tick, watch the four blank cycles, finish on the first SHOW sample.
  task automatic step(output int fd_cnt, output bit blank_ok);
    tick();
    fd_cnt   = int'(bus.frame_done);
    blank_ok = (bus.O_AN === 8'hFF) && (bus.O_SEG === 7'h7F) && (bus.O_DP === 1'b1);
    repeat (3) begin
      @(negedge clk);
      fd_cnt   += int'(bus.frame_done);
      blank_ok &= (bus.O_AN === 8'hFF) && (bus.O_SEG === 7'h7F) && (bus.O_DP === 1'b1);
    end
    @(negedge clk);
    fd_cnt += int'(bus.frame_done);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.scan_clk = 1'b0; bus.data = '0; bus.dot = '0; bus.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.O_AN !== 8'hFF) begin n_err++; $display("FAIL reset_an got %h want ff", bus.O_AN); end
    n_cmp++; if (bus.O_SEG !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %h want 7f", bus.O_SEG); end
    n_cmp++; if (bus.O_DP !== 1'b1) begin n_err++; $display("FAIL reset_dp got %b want 1", bus.O_DP); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd got %b want 0", bus.frame_done); end
    rst = 1'b0;
  endtask

  task automatic test_first_digit();
    bus.data = 32'h1234ABCD;
    tick();
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL first_fd got %b want 0", bus.frame_done); end
    for (int s = 0; s < 4; s++) begin
      if (s != 0) @(negedge clk);
      n_cmp++; if (bus.O_AN !== 8'hFF) begin n_err++; $display("FAIL first_blank%0d got %h want ff", s, bus.O_AN); end
    end
    @(negedge clk);
    n_cmp++; if (bus.O_AN !== 8'hFE) begin n_err++; $display("FAIL first_an got %h want fe", bus.O_AN); end
    n_cmp++; if (bus.O_SEG !== 7'h21) begin n_err++; $display("FAIL first_seg got %h want 21", bus.O_SEG); end
    n_cmp++; if (bus.O_DP !== 1'b1) begin n_err++; $display("FAIL first_dp got %b want 1", bus.O_DP); end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    int fd; bit bok; int fd_total = 0;
    for (int k = 1; k <= 8; k++) begin
      int i = k % 8;
      logic [7:0] exp_an = ~(8'h01 << i);
      step(fd, bok);
      fd_total += fd;
      n_cmp++; if (!bok) begin n_err++; $display("FAIL scan_blank%0d got not-dark want dark", k); end
      n_cmp++; if (bus.O_AN !== exp_an) begin n_err++; $display("FAIL scan_an%0d got %h want %h", k, bus.O_AN, exp_an); end
      n_cmp++; if (bus.O_SEG !== exp_seg[i]) begin n_err++; $display("FAIL scan_seg%0d got %h want %h", k, bus.O_SEG, exp_seg[i]); end
      n_cmp++; if (fd !== ((k == 8) ? 1 : 0)) begin n_err++; $display("FAIL scan_fd%0d got %0d want %0d", k, fd, (k == 8) ? 1 : 0); end
    end
    n_cmp++; if (fd_total !== 1) begin n_err++; $display("FAIL scan_fd_total got %0d want 1", fd_total); end
  endtask

  task automatic test_midframe();
    logic [6:0] old_seg [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    int fd; bit bok;
    step(fd, bok);
    bus.data = 32'h0;
    for (int k = 2; k <= 15; k++) begin
      int i = k % 8;
      logic [6:0] exp = (k < 8) ? old_seg[i] : 7'h40;
      step(fd, bok);
      n_cmp++; if (bus.O_SEG !== exp) begin n_err++; $display("FAIL mid_seg%0d got %h want %h", k, bus.O_SEG, exp); end
    end
  endtask

  task automatic test_lz();
    logic [6:0] exp_seg [8] = '{7'h40, 7'h12, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    int fd; bit bok;
    bus.data = 32'h00000050;
    bus.blank_lz = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(fd, bok);
      n_cmp++; if (bus.O_SEG !== exp_seg[i]) begin n_err++; $display("FAIL lz_seg%0d got %h want %h", i, bus.O_SEG, exp_seg[i]); end
      n_cmp++; if (bus.O_AN !== ~(8'h01 << i)) begin n_err++; $display("FAIL lz_an%0d got %h want %h", i, bus.O_AN, ~(8'h01 << i)); end
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_dot();
    int fd; bit bok;
    bus.data = 32'h0;
    bus.dot  = 8'h01;
    for (int i = 0; i < 8; i++) begin
      step(fd, bok);
      n_cmp++; if (!bok) begin n_err++; $display("FAIL dot_blank%0d got lit want dark", i); end
      n_cmp++; if (bus.O_DP !== ((i == 0) ? 1'b0 : 1'b1)) begin
        n_err++; $display("FAIL dot_dp%0d got %b want %b", i, bus.O_DP, (i == 0) ? 1'b0 : 1'b1);
      end
    end
    bus.dot = 8'h00;
  endtask

  task automatic test_tick_in_blank();
    int fd; bit bok;
    step(fd, bok);
    tick();
    tick();
    for (int s = 0; s < 4; s++) begin
      if (s != 0) @(negedge clk);
      n_cmp++; if (bus.O_AN !== 8'hFF) begin n_err++; $display("FAIL rblank%0d got %h want ff", s, bus.O_AN); end
    end
    @(negedge clk);
    n_cmp++; if (bus.O_AN !== 8'hFB) begin n_err++; $display("FAIL rblank_an got %h want fb", bus.O_AN); end
    n_cmp++; if (bus.O_SEG !== 7'h40) begin n_err++; $display("FAIL rblank_seg got %h want 40", bus.O_SEG); end
  endtask

  task automatic test_rst_with_tick();
    int fd; bit bok; bit hold_ok = 1'b1;
    @(negedge clk);
    rst = 1'b1; bus.scan_clk = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.O_AN !== 8'hFF) begin n_err++; $display("FAIL rtick_an got %h want ff", bus.O_AN); end
    n_cmp++; if (bus.O_SEG !== 7'h7F) begin n_err++; $display("FAIL rtick_seg got %h want 7f", bus.O_SEG); end
    n_cmp++; if (bus.O_DP !== 1'b1) begin n_err++; $display("FAIL rtick_dp got %b want 1", bus.O_DP); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL rtick_fd got %b want 0", bus.frame_done); end
    rst = 1'b0; bus.scan_clk = 1'b0;
    bus.data = 32'h000000A5;
    step(fd, bok);
    n_cmp++; if (fd !== 0) begin n_err++; $display("FAIL rel_fd got %0d want 0", fd); end
    n_cmp++; if (bus.O_AN !== 8'hFE) begin n_err++; $display("FAIL rel_an got %h want fe", bus.O_AN); end
    n_cmp++; if (bus.O_SEG !== 7'h12) begin n_err++; $display("FAIL rel_seg got %h want 12", bus.O_SEG); end
    bus.data = 32'hFFFFFFFF;
    repeat (6) begin
      @(negedge clk);
      hold_ok &= (bus.O_AN === 8'hFE) && (bus.O_SEG === 7'h12);
    end
    n_cmp++; if (!hold_ok) begin n_err++; $display("FAIL show_hold got %h/%h want fe/12", bus.O_AN, bus.O_SEG); end
  endtask

  initial begin
    test_reset();
    test_first_digit();
    test_scan();
    test_midframe();
    test_lz();
    test_dot();
    test_tick_in_blank();
    test_rst_with_tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
